data_split2: RTL and testbench



---
 rtl/split_pkg.sv | 19 +
 rtl/split_fifo.sv | 56 +++++
 rtl/data_split2.sv | 79 +++++++
 tb/tb_data_split2.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared types and constants for the data_split2 stream splitter and its lane FIFO.
package split_pkg;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_e;

    // Occupancy must reach DEPTH itself, hence one bit more than the pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_COUNT_W = count_width(DEFAULT_DEPTH);

endpackage

// File: rtl/split_fifo.sv
// Single-clock lane FIFO for data_split2: push/pop/full/count, head word shown
// directly from storage and forced to zero while empty.
module split_fifo
    import split_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = count_width(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/data_split2.sv
// Registered 1-to-2 stream splitter with an independent FIFO per output lane.
// Define SPLIT_ROUNDROBIN_EN to ignore sel and alternate lanes 1,2,1,2 on accepted words.
module data_split2
    import split_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             inValid,
    input  logic             sel,
    output logic             inReady,
    output logic [WIDTH-1:0] dataOut1,
    output logic             out1Valid,
    input  logic             out1Ready,
    output logic [WIDTH-1:0] dataOut2,
    output logic             out2Valid,
    input  logic             out2Ready
);

    localparam int CW = count_width(DEPTH);

    lane_e         lane;
    logic          accept;
    logic          push1, push2;
    logic          pop1, pop2;
    logic          full1, full2;
    logic [CW-1:0] count1, count2;

`ifdef SPLIT_ROUNDROBIN_EN
    lane_e toggle;

    // Advances only on an accepted word, so a stall keeps the same destination.
    always_ff @(posedge clk) begin
        if (rst)         toggle <= LANE1;
        else if (accept) toggle <= (toggle == LANE1) ? LANE2 : LANE1;
    end

    assign lane = toggle;
`else
    assign lane = lane_e'(sel);
`endif

    // A full lane refuses input even when it pops this same cycle.
    assign inReady   = !rst && !((lane == LANE1) ? full1 : full2);
    assign accept    = inValid && inReady;
    assign push1     = accept && (lane == LANE1);
    assign push2     = accept && (lane == LANE2);

    assign out1Valid = (count1 != '0);
    assign out2Valid = (count2 != '0);
    assign pop1      = out1Valid && out1Ready;
    assign pop2      = out2Valid && out2Ready;

    split_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (pop1),
        .din   (dataIn),
        .dout  (dataOut1),
        .full  (full1),
        .count (count1)
    );

    split_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push2),
        .pop   (pop2),
        .din   (dataIn),
        .dout  (dataOut2),
        .full  (full2),
        .count (count2)
    );

endmodule

// File: tb/tb_data_split2.sv
// Self-checking bench for data_split2: directed steps plus random traffic,
// compared every cycle against a queue-per-lane reference model.
module tb_data_split2;

    localparam int W = 2;
    localparam int D = 2;
`ifdef SPLIT_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dataIn;
    logic         inValid;
    logic         sel;
    logic         inReady;
    logic [W-1:0] dataOut1;
    logic         out1Valid;
    logic         out1Ready;
    logic [W-1:0] dataOut2;
    logic         out2Valid;
    logic         out2Ready;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic         tog = 1'b0;

    data_split2 #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .dataIn    (dataIn),
        .inValid   (inValid),
        .sel       (sel),
        .inReady   (inReady),
        .dataOut1  (dataOut1),
        .out1Valid (out1Valid),
        .out1Ready (out1Ready),
        .dataOut2  (dataOut2),
        .out2Valid (out2Valid),
        .out2Ready (out2Ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare against the model, clock, then advance the model.
    task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r1, input logic r2, input logic rs);
        logic lane;
        logic exp_rdy;
        rst = rs; inValid = v; sel = s; dataIn = d; out1Ready = r1; out2Ready = r2;
        #1;
        lane    = RR ? tog : s;
        exp_rdy = !rs && (lane ? (q2.size() < D) : (q1.size() < D));
        check("in_ready",   inReady,   exp_rdy);
        check("out1_valid", out1Valid, q1.size() != 0);
        check("data_out1",  dataOut1,  (q1.size() != 0) ? q1[0] : '0);
        check("out2_valid", out2Valid, q2.size() != 0);
        check("data_out2",  dataOut2,  (q2.size() != 0) ? q2[0] : '0);
        @(posedge clk);
        if (rs) begin
            q1.delete();
            q2.delete();
            tog = 1'b0;
        end else begin
            if (r1 && q1.size() != 0) void'(q1.pop_front());
            if (r2 && q2.size() != 0) void'(q2.pop_front());
            if (v && exp_rdy) begin
                if (lane) q2.push_back(d);
                else      q1.push_back(d);
                tog = ~tog;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; sel = 1'b0; dataIn = '0; out1Ready = 1'b0; out2Ready = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
        check("reset_out1_valid", out1Valid, 1'b0);
        check("reset_data_out2", dataOut2, '0);

`ifndef SPLIT_ROUNDROBIN_EN
        // Single word into lane 1.
        cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        check("single_out1_valid", out1Valid, 1'b1);
        check("single_data_out1", dataOut1, 2'b10);
        check("single_out2_valid", out2Valid, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Fill lane 2 while stalled; lane 1 stays writable.
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        inValid = 1'b0; sel = 1'b1; #1;
        check("lane2_full_ready", inReady, 1'b0);
        sel = 1'b0; #1;
        check("lane1_open_ready", inReady, 1'b1);
        cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        check("lane2_second_head", dataOut2, 2'b11);
        cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        check("lane2_drained", out2Valid, 1'b0);

        // Full lane refuses a push even while popping.
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        check("full_pop_head", dataOut1, 2'b01);
        #1;
        check("after_full_pop_ready", inReady, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check("full_pop_nothing_written", out1Valid, 1'b0);

        // Interleaved steering with both consumers ready.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] dv;
            dv = W'(i);
            cycle(1'b1, dv[0], dv, 1'b1, 1'b1, 1'b0);
            check("interleave_head", dv[0] ? dataOut2 : dataOut1, dv);
        end
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);

        // Reset mid-stream with a push offered during reset.
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        check("midreset_out1_valid", out1Valid, 1'b0);
        check("midreset_out2_valid", out2Valid, 1'b0);
        check("midreset_data_out1", dataOut1, '0);
        check("midreset_data_out2", dataOut2, '0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`else
        // Alternating destination with sel held at 1.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] dv;
            dv = W'(i);
            cycle(1'b1, 1'b1, dv, 1'b1, 1'b1, 1'b0);
            check("rr_head", dv[0] ? dataOut2 : dataOut1, dv);
        end
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);

        // Stall on a full lane 1 must not advance the toggle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        check("rr_stall_head", dataOut1, 2'b00);
        cycle(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        check("rr_stall_to_lane1", dataOut1, 2'b11);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
`endif

        // Random traffic, occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        check("final_out1_valid", out1Valid, 1'b0);
        check("final_out2_valid", out2Valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
